// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU among NUM_REQ
// requesters. It has a single registered result slot and 1-cycle latency.
// Optional feature macro: ALU_ARB_LOCK_EN (adds req_lock_i and lock state).
// Command encoding (alu_cmd_t, 4 bits):
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU,
//   10..15 are undefined and yield 0.
module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*4-1:0]  req_cmd_i,
  input  logic [NUM_REQ*32-1:0] req_lhs_i,
  input  logic [NUM_REQ*32-1:0] req_rhs_i,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    req_lock_i,
`endif
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [31:0]           rsp_res_o
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, rr_ptr_q, gnt_idx;
  logic [31:0]     res_q, alu_res, alu_lhs, alu_rhs;
  logic [3:0]      alu_cmd;
  logic [4:0]      shamt;
  logic            gnt_found, can_accept, accept, drain;
  logic [NUM_REQ-1:0] eligible;

`ifdef ALU_ARB_LOCK_EN
  logic            lock_q;
  logic [IW-1:0]   lock_owner_q;
`endif

  // Per-requester eligibility plus the one-hot ready / response-valid vectors.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
`ifdef ALU_ARB_LOCK_EN
    assign eligible[gi] = req_valid_i[gi] & (~lock_q | (lock_owner_q == IW'(gi)));
`else
    assign eligible[gi] = req_valid_i[gi];
`endif
    assign req_ready_o[gi] = accept & (gnt_idx == IW'(gi));
    assign rsp_valid_o[gi] = (state_q == ST_FULL) & (owner_q == IW'(gi));
  end

  // Round-robin scan: the first eligible requester starting at rr_ptr wins.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && eligible[IW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

  // Winner's operands drive the shared ALU.
  assign alu_cmd = req_cmd_i[gnt_idx*4 +: 4];
  assign alu_lhs = req_lhs_i[gnt_idx*32 +: 32];
  assign alu_rhs = req_rhs_i[gnt_idx*32 +: 32];
  assign shamt   = alu_rhs[4:0];

  // Shared combinational ALU; results wrap, and undefined commands give 0.
  always_comb begin
    alu_res = '0;
    case (alu_cmd)
      4'd0:    alu_res = alu_lhs + alu_rhs;
      4'd1:    alu_res = alu_lhs - alu_rhs;
      4'd2:    alu_res = alu_lhs & alu_rhs;
      4'd3:    alu_res = alu_lhs | alu_rhs;
      4'd4:    alu_res = alu_lhs ^ alu_rhs;
      4'd5:    alu_res = alu_lhs << shamt;
      4'd6:    alu_res = alu_lhs >> shamt;
      4'd7:    alu_res = $unsigned($signed(alu_lhs) >>> shamt);
      4'd8:    alu_res = {31'b0, $signed(alu_lhs) < $signed(alu_rhs)};
      4'd9:    alu_res = {31'b0, alu_lhs < alu_rhs};
      default: alu_res = '0;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Slot next state: an accept always refills; a lone drain empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (accept)     state_d = ST_FULL;
        else if (drain) state_d = ST_EMPTY;
      end
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Slot outputs: the slot may accept when empty or when its owner drains now.
  always_comb begin
    drain      = (state_q == ST_FULL) & rsp_ready_i[owner_q];
    can_accept = (state_q == ST_EMPTY) | drain;
    accept     = gnt_found & can_accept & ~rst_i;
  end

  // Result slot, owner and round-robin pointer update on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      res_q    <= alu_res;
      owner_q  <= gnt_idx;
      rr_ptr_q <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

`ifdef ALU_ARB_LOCK_EN
  // Lock follows the lock bit of each accepted op. While locked, only the
  // owner can be accepted, so its next unlocked op is what releases the lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= '0;
    end else if (accept) begin
      lock_q       <= req_lock_i[gnt_idx];
      lock_owner_q <= gnt_idx;
    end
  end
`endif

  assign rsp_res_o = res_q;

endmodule
